ctrl_word_pipe: RTL and testbench

CTRL_WORD_PIPE -- requirements
Module: ctrl_word_pipe

---
 rtl/riscv_ctrl_pkg.sv | 74 +++++++
 rtl/ctrl_decode.sv | 123 ++++++++++++
 rtl/ctrl_word_pipe.sv | 100 ++++++++++
 tb/tb_ctrl_word_pipe.sv | 366 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_ctrl_pkg.sv
// Shared control-word field positions, select encodings and RV32I opcode constants
// for the decode stage and the control-word pipeline.
package riscv_ctrl_pkg;

    localparam int CW_W        = 16;
    localparam int REG_WEN_BIT = 0;
    localparam int IMM_SEL_LSB = 1;
    localparam int IMM_SEL_MSB = 3;
    localparam int BR_LUN_BIT  = 4;
    localparam int A_SEL_BIT   = 5;
    localparam int B_SEL_BIT   = 6;
    localparam int ALU_SEL_LSB = 7;
    localparam int ALU_SEL_MSB = 10;
    localparam int MEM_RW_BIT  = 11;
    localparam int WB_SEL_LSB  = 12;
    localparam int WB_SEL_MSB  = 13;
    localparam int PC_SEL_LSB  = 14;
    localparam int PC_SEL_MSB  = 15;

    typedef enum logic [2:0] {
        IMM_I = 3'd0,
        IMM_S = 3'd1,
        IMM_B = 3'd2,
        IMM_U = 3'd3,
        IMM_J = 3'd4
    } imm_sel_e;

    typedef enum logic [1:0] {
        WB_MEM = 2'd0,
        WB_ALU = 2'd1,
        WB_PC4 = 2'd2
    } wb_sel_e;

    typedef enum logic [1:0] {
        PC_SEQ    = 2'd0,
        PC_JUMP   = 2'd1,
        PC_BRANCH = 2'd2
    } pc_sel_e;

    localparam logic [3:0] ALU_ADD    = 4'b0000;
    localparam logic [3:0] ALU_PASS_B = 4'b1111;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I_ALU  = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    // Field order matches the bit positions above, MSB first.
    typedef struct packed {
        pc_sel_e    pc_sel;
        wb_sel_e    wb_sel;
        logic       mem_rw;
        logic [3:0] alu_sel;
        logic       b_sel;
        logic       a_sel;
        logic       br_lun;
        imm_sel_e   imm_sel;
        logic       reg_wen;
    } ctrl_word_t;

    typedef struct packed {
        logic            valid;
        logic [4:0]      rd;
        logic [CW_W-1:0] hex;
    } stage_t;

    localparam stage_t BUBBLE = '{valid: 1'b0, rd: 5'd0, hex: '0};

endpackage

// File: rtl/ctrl_decode.sv
// Combinational RV32I decode: instruction word to 16-bit control word,
// plus the source-register usage needed by the load-use check.
module ctrl_decode
    import riscv_ctrl_pkg::*;
(
    input  logic [31:0]     instr,
    input  logic            instr_valid,
    output logic [CW_W-1:0] id_hex,
    output logic [5:0]      id_instr_code,
    output logic            illegal,
    output logic            rs1_used,
    output logic            rs2_used,
    output logic [4:0]      rs1,
    output logic [4:0]      rs2,
    output logic [4:0]      rd
);

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic       funct7_5;
    logic       known;
    ctrl_word_t cw;
    logic       unused_bits;

    assign opcode      = instr[6:0];
    assign funct3      = instr[14:12];
    assign funct7_5    = instr[30];
    assign rd          = instr[11:7];
    assign rs1         = instr[19:15];
    assign rs2         = instr[24:20];
    assign unused_bits = ^{instr[31], instr[29:25]};

    always_comb begin
        cw       = '0;
        known    = 1'b1;
        rs1_used = 1'b0;
        rs2_used = 1'b0;
        case (opcode)
            OP_R: begin
                cw.reg_wen = 1'b1;
                cw.alu_sel = {funct7_5, funct3};
                cw.wb_sel  = WB_ALU;
                rs1_used   = 1'b1;
                rs2_used   = 1'b1;
            end
            OP_I_ALU: begin
                // Only the shift-right pair distinguishes on funct7; other immediates carry data there.
                cw.reg_wen = 1'b1;
                cw.imm_sel = IMM_I;
                cw.b_sel   = 1'b1;
                cw.alu_sel = {funct7_5 & (funct3 == 3'b101), funct3};
                cw.wb_sel  = WB_ALU;
                rs1_used   = 1'b1;
            end
            OP_LOAD: begin
                cw.reg_wen = 1'b1;
                cw.imm_sel = IMM_I;
                cw.br_lun  = funct3[2];
                cw.b_sel   = 1'b1;
                cw.alu_sel = ALU_ADD;
                cw.wb_sel  = WB_MEM;
                rs1_used   = 1'b1;
            end
            OP_STORE: begin
                cw.imm_sel = IMM_S;
                cw.b_sel   = 1'b1;
                cw.mem_rw  = 1'b1;
                rs1_used   = 1'b1;
                rs2_used   = 1'b1;
            end
            OP_BRANCH: begin
                cw.imm_sel = IMM_B;
                cw.br_lun  = funct3[1];
                cw.a_sel   = 1'b1;
                cw.b_sel   = 1'b1;
                cw.pc_sel  = PC_BRANCH;
                rs1_used   = 1'b1;
                rs2_used   = 1'b1;
            end
            OP_JAL: begin
                cw.reg_wen = 1'b1;
                cw.imm_sel = IMM_J;
                cw.a_sel   = 1'b1;
                cw.b_sel   = 1'b1;
                cw.wb_sel  = WB_PC4;
                cw.pc_sel  = PC_JUMP;
            end
            OP_JALR: begin
                cw.reg_wen = 1'b1;
                cw.imm_sel = IMM_I;
                cw.b_sel   = 1'b1;
                cw.wb_sel  = WB_PC4;
                cw.pc_sel  = PC_JUMP;
                rs1_used   = 1'b1;
            end
            OP_LUI: begin
                cw.reg_wen = 1'b1;
                cw.imm_sel = IMM_U;
                cw.b_sel   = 1'b1;
                cw.alu_sel = ALU_PASS_B;
                cw.wb_sel  = WB_ALU;
            end
            OP_AUIPC: begin
                cw.reg_wen = 1'b1;
                cw.imm_sel = IMM_U;
                cw.a_sel   = 1'b1;
                cw.b_sel   = 1'b1;
                cw.wb_sel  = WB_ALU;
            end
            default: known = 1'b0;
        endcase
        if (!instr_valid || !known) begin
            cw       = '0;
            rs1_used = 1'b0;
            rs2_used = 1'b0;
        end
    end

    assign illegal       = instr_valid & ~known;
    assign id_hex        = cw;
    assign id_instr_code = {illegal, opcode[6:2]};

endmodule

// File: rtl/ctrl_word_pipe.sv
// EX/MEM/WB control-word pipeline with load-use bubble insertion,
// freeze (stall) and branch-kill (flush) handling.
module ctrl_word_pipe
    import riscv_ctrl_pkg::*;
#(
    parameter int HAZARD_EN = 1
)
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic [31:0]     instr,
    input  logic            instr_valid,
    input  logic            stall_i,
    input  logic            flush_i,
    output logic [CW_W-1:0] id_hex,
    output logic [5:0]      id_instr_code,
    output logic [CW_W-1:0] ex_hex,
    output logic [CW_W-1:0] mem_hex,
    output logic [CW_W-1:0] wb_hex,
    output logic            ex_valid,
    output logic            mem_valid,
    output logic            wb_valid,
    output logic            hazard_o,
    output logic            illegal_o
);

    logic       rs1_used;
    logic       rs2_used;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [4:0] id_rd;
    logic       load_use;
    logic       unused_rd;

    stage_t ex_q, mem_q, wb_q;
    stage_t ex_d, mem_d, wb_d;

    ctrl_decode u_decode (
        .instr         (instr),
        .instr_valid   (instr_valid),
        .id_hex        (id_hex),
        .id_instr_code (id_instr_code),
        .illegal       (illegal_o),
        .rs1_used      (rs1_used),
        .rs2_used      (rs2_used),
        .rs1           (rs1),
        .rs2           (rs2),
        .rd            (id_rd)
    );

    always_comb begin
        load_use = ex_q.valid
                && ex_q.hex[REG_WEN_BIT]
                && (wb_sel_e'(ex_q.hex[WB_SEL_MSB:WB_SEL_LSB]) == WB_MEM)
                && (ex_q.rd != 5'd0)
                && ((rs1_used && (rs1 == ex_q.rd)) || (rs2_used && (rs2 == ex_q.rd)));
    end

    // A flush already bubbles EX, so the load-use bubble is suppressed rather than stacked.
    assign hazard_o = (HAZARD_EN != 0) && load_use && !flush_i;

    always_comb begin
        ex_d  = ex_q;
        mem_d = mem_q;
        wb_d  = wb_q;
        if (!stall_i) begin
            wb_d  = mem_q;
            mem_d = ex_q;
            if (flush_i || hazard_o) begin
                ex_d = BUBBLE;
            end else begin
                ex_d.valid = instr_valid & ~illegal_o;
                ex_d.hex   = id_hex;
                ex_d.rd    = (instr_valid & ~illegal_o) ? id_rd : 5'd0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_q  <= BUBBLE;
            mem_q <= BUBBLE;
            wb_q  <= BUBBLE;
        end else begin
            ex_q  <= ex_d;
            mem_q <= mem_d;
            wb_q  <= wb_d;
        end
    end

    assign unused_rd = ^wb_q.rd;

    assign ex_hex    = ex_q.hex;
    assign mem_hex   = mem_q.hex;
    assign wb_hex    = wb_q.hex;
    assign ex_valid  = ex_q.valid;
    assign mem_valid = mem_q.valid;
    assign wb_valid  = wb_q.valid;

endmodule

// File: tb/tb_ctrl_word_pipe.sv
// Scenario bench for ctrl_word_pipe: decode, latency, load-use, flush, stall,
// async reset and a scoreboarded instruction stream.
module tb_ctrl_word_pipe;

    logic        clk;
    logic        rst_n;
    logic [31:0] instr;
    logic        instr_valid;
    logic        stall_i;
    logic        flush_i;
    logic [15:0] id_hex;
    logic [5:0]  id_instr_code;
    logic [15:0] ex_hex, mem_hex, wb_hex;
    logic        ex_valid, mem_valid, wb_valid;
    logic        hazard_o;
    logic        illegal_o;

    int checks = 0;
    int errors = 0;
    logic [15:0] sb[$];

    localparam int N = 14;
    localparam logic [31:0] S_INSTR [N] = '{
        32'h00500093, 32'h002081B3, 32'h402081B3, 32'h4020D093,
        32'h0020A223, 32'h0020E463, 32'h010000EF, 32'h00008067,
        32'h123452B7, 32'h00001297, 32'h0000C283, 32'h00128333,
        32'h0000007F, 32'h0000A283};
    localparam logic [15:0] S_HEX [N] = '{
        16'h1041, 16'h1001, 16'h1401, 16'h16C1,
        16'h0842, 16'h8074, 16'h6069, 16'h6041,
        16'h17C7, 16'h1067, 16'h0051, 16'h1001,
        16'h0000, 16'h0041};
    localparam logic S_LEGAL [N] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1,
                                     1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};

    localparam logic [31:0] I_ADD  = 32'h002081B3;
    localparam logic [31:0] I_SUB  = 32'h402081B3;
    localparam logic [31:0] I_ADDI = 32'h00500093;
    localparam logic [31:0] I_LW   = 32'h0000A283;
    localparam logic [31:0] I_USE  = 32'h00128333;
    localparam logic [31:0] I_ILL  = 32'h0000007F;

    ctrl_word_pipe #(.HAZARD_EN(1)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .instr         (instr),
        .instr_valid   (instr_valid),
        .stall_i       (stall_i),
        .flush_i       (flush_i),
        .id_hex        (id_hex),
        .id_instr_code (id_instr_code),
        .ex_hex        (ex_hex),
        .mem_hex       (mem_hex),
        .wb_hex        (wb_hex),
        .ex_valid      (ex_valid),
        .mem_valid     (mem_valid),
        .wb_valid      (wb_valid),
        .hazard_o      (hazard_o),
        .illegal_o     (illegal_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [31:0] w, input logic v);
        instr       = w;
        instr_valid = v;
    endtask

    task automatic drain;
        drive(32'h0, 1'b0);
        stall_i = 1'b0;
        flush_i = 1'b0;
        repeat (4) tick();
    endtask

    task automatic test_reset;
        checks++;
        if ({ex_hex, mem_hex, wb_hex} !== 48'h0 || {ex_valid, mem_valid, wb_valid, hazard_o} !== 4'b0) begin
            errors++;
            $display("FAIL reset_state got ex=%h mem=%h wb=%h v=%b%b%b hz=%b exp all 0",
                     ex_hex, mem_hex, wb_hex, ex_valid, mem_valid, wb_valid, hazard_o);
        end
    endtask

    task automatic test_decode;
        drive(I_ILL, 1'b0);
        #1;
        checks++;
        if (illegal_o !== 1'b0 || id_hex !== 16'h0) begin
            errors++;
            $display("FAIL decode_invalid got ill=%b hex=%h exp ill=0 hex=0000", illegal_o, id_hex);
        end
        drive(I_ADD, 1'b1);
        #1;
        checks++;
        if (id_instr_code !== 6'h0C || illegal_o !== 1'b0 || id_hex !== 16'h1001) begin
            errors++;
            $display("FAIL decode_add got code=%h ill=%b hex=%h exp code=0c ill=0 hex=1001",
                     id_instr_code, illegal_o, id_hex);
        end
        drain();
    endtask

    task automatic test_latency;
        drive(I_ADD, 1'b1);
        tick();
        drive(32'h0, 1'b0);
        checks++;
        if (ex_hex !== 16'h1001 || ex_valid !== 1'b1 || mem_valid !== 1'b0) begin
            errors++;
            $display("FAIL lat_ex got ex=%h v=%b memv=%b exp ex=1001 v=1 memv=0", ex_hex, ex_valid, mem_valid);
        end
        tick();
        checks++;
        if (mem_hex !== 16'h1001 || mem_valid !== 1'b1 || ex_valid !== 1'b0 || wb_valid !== 1'b0) begin
            errors++;
            $display("FAIL lat_mem got mem=%h v=%b exv=%b wbv=%b exp mem=1001 v=1 exv=0 wbv=0",
                     mem_hex, mem_valid, ex_valid, wb_valid);
        end
        tick();
        checks++;
        if (wb_hex !== 16'h1001 || wb_valid !== 1'b1 || mem_valid !== 1'b0) begin
            errors++;
            $display("FAIL lat_wb got wb=%h v=%b memv=%b exp wb=1001 v=1 memv=0", wb_hex, wb_valid, mem_valid);
        end
        drain();
    endtask

    task automatic test_load_use;
        drive(I_LW, 1'b1);
        #1;
        checks++;
        if (id_hex !== 16'h0041 || hazard_o !== 1'b0) begin
            errors++;
            $display("FAIL lu_lw_decode got hex=%h hz=%b exp hex=0041 hz=0", id_hex, hazard_o);
        end
        tick();
        drive(I_USE, 1'b1);
        #1;
        checks++;
        if (hazard_o !== 1'b1) begin
            errors++;
            $display("FAIL lu_hazard got %b exp 1", hazard_o);
        end
        tick();
        checks++;
        if (ex_valid !== 1'b0 || ex_hex !== 16'h0 || mem_hex !== 16'h0041 || mem_valid !== 1'b1) begin
            errors++;
            $display("FAIL lu_bubble got ex=%h v=%b mem=%h mv=%b exp ex=0000 v=0 mem=0041 mv=1",
                     ex_hex, ex_valid, mem_hex, mem_valid);
        end
        checks++;
        if (hazard_o !== 1'b0) begin
            errors++;
            $display("FAIL lu_hazard_clear got %b exp 0", hazard_o);
        end
        tick();
        checks++;
        if (ex_hex !== 16'h1001 || ex_valid !== 1'b1) begin
            errors++;
            $display("FAIL lu_add_enters got ex=%h v=%b exp 1001 v=1", ex_hex, ex_valid);
        end
        drain();
    endtask

    task automatic test_flush;
        drive(I_ADD, 1'b1);
        tick();
        drive(I_SUB, 1'b1);
        flush_i = 1'b1;
        tick();
        flush_i = 1'b0;
        drive(32'h0, 1'b0);
        checks++;
        if (ex_valid !== 1'b0 || ex_hex !== 16'h0 || mem_hex !== 16'h1001 || mem_valid !== 1'b1) begin
            errors++;
            $display("FAIL flush_kill got ex=%h v=%b mem=%h mv=%b exp ex=0000 v=0 mem=1001 mv=1",
                     ex_hex, ex_valid, mem_hex, mem_valid);
        end
        drain();
        drive(I_LW, 1'b1);
        tick();
        drive(I_USE, 1'b1);
        flush_i = 1'b1;
        #1;
        checks++;
        if (hazard_o !== 1'b0) begin
            errors++;
            $display("FAIL flush_hz_mask got %b exp 0", hazard_o);
        end
        tick();
        flush_i = 1'b0;
        drive(I_ADDI, 1'b1);
        #1;
        checks++;
        if (ex_valid !== 1'b0 || mem_hex !== 16'h0041 || hazard_o !== 1'b0) begin
            errors++;
            $display("FAIL flush_hz_bubble got exv=%b mem=%h hz=%b exp exv=0 mem=0041 hz=0",
                     ex_valid, mem_hex, hazard_o);
        end
        tick();
        checks++;
        if (ex_hex !== 16'h1041 || ex_valid !== 1'b1) begin
            errors++;
            $display("FAIL flush_single_bubble got ex=%h v=%b exp 1041 v=1", ex_hex, ex_valid);
        end
        drain();
    endtask

    task automatic test_illegal;
        drive(I_ILL, 1'b1);
        #1;
        checks++;
        if (illegal_o !== 1'b1 || id_hex !== 16'h0 || id_instr_code !== 6'h3F) begin
            errors++;
            $display("FAIL illegal_decode got ill=%b hex=%h code=%h exp ill=1 hex=0000 code=3f",
                     illegal_o, id_hex, id_instr_code);
        end
        tick();
        checks++;
        if (ex_valid !== 1'b0 || ex_hex !== 16'h0) begin
            errors++;
            $display("FAIL illegal_ex got ex=%h v=%b exp 0000 v=0", ex_hex, ex_valid);
        end
        drain();
    endtask

    task automatic test_stall;
        drive(I_ADD, 1'b1);
        tick();
        drive(I_ADDI, 1'b1);
        tick();
        drive(I_LW, 1'b1);
        tick();
        drive(I_USE, 1'b1);
        stall_i = 1'b1;
        #1;
        checks++;
        if (hazard_o !== 1'b1) begin
            errors++;
            $display("FAIL stall_hazard got %b exp 1", hazard_o);
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (ex_hex !== 16'h0041 || mem_hex !== 16'h1041 || wb_hex !== 16'h1001 ||
                {ex_valid, mem_valid, wb_valid} !== 3'b111) begin
                errors++;
                $display("FAIL stall_hold[%0d] got ex=%h mem=%h wb=%h exp 0041 1041 1001 all valid",
                         i, ex_hex, mem_hex, wb_hex);
            end
        end
        stall_i = 1'b0;
        tick();
        checks++;
        if (ex_valid !== 1'b0 || mem_hex !== 16'h0041 || wb_hex !== 16'h1041) begin
            errors++;
            $display("FAIL stall_release got exv=%b mem=%h wb=%h exp exv=0 mem=0041 wb=1041",
                     ex_valid, mem_hex, wb_hex);
        end
        drain();
    endtask

    task automatic test_stream;
        int idx = 0;
        int cyc = 0;
        logic [15:0] exp_w;
        sb.delete();
        while ((idx < N || sb.size() != 0) && cyc < 100) begin
            if (idx < N) drive(S_INSTR[idx], 1'b1);
            else drive(32'h0, 1'b0);
            #1;
            if (idx < N) begin
                checks++;
                if (id_hex !== S_HEX[idx] || illegal_o !== ~S_LEGAL[idx]) begin
                    errors++;
                    $display("FAIL stream_decode[%0d] got hex=%h ill=%b exp hex=%h ill=%b",
                             idx, id_hex, illegal_o, S_HEX[idx], ~S_LEGAL[idx]);
                end
                if (!hazard_o) begin
                    if (S_LEGAL[idx]) sb.push_back(S_HEX[idx]);
                    idx++;
                end
            end
            tick();
            cyc++;
            if (wb_valid) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL stream_wb_extra got wb=%h exp nothing", wb_hex);
                end else begin
                    exp_w = sb.pop_front();
                    if (wb_hex !== exp_w) begin
                        errors++;
                        $display("FAIL stream_wb got %h exp %h", wb_hex, exp_w);
                    end
                end
            end
        end
        checks++;
        if (idx != N || sb.size() != 0) begin
            errors++;
            $display("FAIL stream_timeout got idx=%0d pending=%0d exp idx=%0d pending=0", idx, sb.size(), N);
        end
        drain();
    endtask

    task automatic test_async_reset;
        drive(I_ADD, 1'b1);
        tick();
        drive(I_SUB, 1'b1);
        tick();
        drive(I_ADDI, 1'b1);
        tick();
        drive(32'h0, 1'b0);
        #3;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({ex_hex, mem_hex, wb_hex} !== 48'h0 || {ex_valid, mem_valid, wb_valid} !== 3'b000) begin
            errors++;
            $display("FAIL async_reset got ex=%h mem=%h wb=%h v=%b%b%b exp all 0",
                     ex_hex, mem_hex, wb_hex, ex_valid, mem_valid, wb_valid);
        end
        #1;
        rst_n = 1'b1;
        drive(I_ADD, 1'b1);
        tick();
        checks++;
        if (ex_hex !== 16'h1001 || ex_valid !== 1'b1 || mem_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_first_edge got ex=%h v=%b mv=%b exp 1001 v=1 mv=0", ex_hex, ex_valid, mem_valid);
        end
        drain();
    endtask

    initial begin
        rst_n       = 1'b0;
        instr       = 32'h0;
        instr_valid = 1'b0;
        stall_i     = 1'b0;
        flush_i     = 1'b0;
        #12;
        test_reset();
        rst_n = 1'b1;
        tick();
        test_decode();
        test_latency();
        test_load_use();
        test_flush();
        test_illegal();
        test_stall();
        test_stream();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
